dm_cache_ctrl: RTL and testbench
================================

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, processor byte-address width.
REQ-002 The block SHALL have parameter IDX_W, default 3, line-index width (2^IDX_W lines of one 32-bit word each).
REQ-003 The block SHALL have parameter MEM_LAT, default 1, memory read latency in cycles (range 1..4).
REQ-004 The block SHALL have parameter CNT_W, default 16, hit/miss counter width.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset; ports as follows:
 clk  in  1  clock, all state on rising edge
 rst  in  1  synchronous active-high reset
 p_req  in  1  processor request strobe
 p_wren  in  1  1 = byte write, 0 = byte read
 p_address  in  ADDR_W  byte address: [1:0] byte offset, [IDX_W+1:2] index, remainder tag
 p_wdata  in  8  write byte
 p_rdata  out  8  read byte, valid when dv=1
 dv  out  1  one-cycle completion pulse
 busy  out  1  request not accepted while high
 flush  in  1  invalidate all lines
 mem_address  out  ADDR_W-2  memory word address
 mem_rden  out  1  memory read strobe
 mem_wren  out  1  memory write strobe
 mem_byteen  out  4  byte enables for mem_wren
 mem_wdata  out  32  write word (byte replicated in all lanes)
 mem_rdata  in  32  read word, valid MEM_LAT cycles after mem_rden
 hit_cnt  out  CNT_W  hit count
 miss_cnt  out  CNT_W  miss count

Function
REQ-006 Direct-mapped cache; per line: valid bit, tag (ADDR_W-2-IDX_W bits), 32-bit data word.
REQ-007 Accept = p_req & ~busy & ~flush; p_address, p_wren, p_wdata captured only on accept (cycle C0).
REQ-008 FSM states: IDLE, COMPARE, MEM_RD, MEM_WAIT, MEM_WR, FLUSH; busy = (state != IDLE).
REQ-009 IDLE -> COMPARE on accept; IDLE -> FLUSH on flush; flush and p_req together: flush wins, request not accepted.
REQ-010 COMPARE (C1): hit = valid[idx] & tag match; hit_cnt or miss_cnt increments once per request, saturating at all-ones.
REQ-011 Read hit: COMPARE -> IDLE; p_rdata = selected byte of cached word, dv=1 in C2.
REQ-012 Read miss: COMPARE -> MEM_RD; C2: mem_rden=1 for one cycle, mem_address = captured word address; MEM_WAIT for MEM_LAT cycles; mem_rdata sampled at end of cycle C2+MEM_LAT, written into line with valid=1 and new tag; dv=1 and p_rdata = selected byte in C3+MEM_LAT; FSM in IDLE that cycle.
REQ-013 Write (hit or miss): COMPARE -> MEM_WR; C2: mem_wren=1 for one cycle, mem_byteen one-hot by offset, mem_wdata = {4{p_wdata}}; dv=1 in C3, p_rdata unchanged.
REQ-014 Write-through, no-write-allocate: write hit updates only the addressed byte of the cached word; write miss leaves the cache unchanged.
REQ-015 FLUSH: one cycle, clears all valid bits, no dv; returns to IDLE.
REQ-016 A new request SHALL be acceptable in the dv cycle (back-to-back operation).
REQ-017 mem_rden, mem_wren and dv SHALL never be high for more than one consecutive cycle per request; mem_rden and mem_wren never high together.
REQ-018 p_rdata holds its last value between reads.

Reset
REQ-019 rst SHALL override all activity, including mid-miss and mid-write: next cycle state=IDLE, all valid bits 0, busy=0, dv=0, mem_rden=0, mem_wren=0, mem_byteen=0, mem_address=0, mem_wdata=0, p_rdata=0, hit_cnt=0, miss_cnt=0.
REQ-020 A memory response arriving after reset SHALL be ignored; tag/data arrays need not be cleared.

Verification
REQ-021 Reset, read 0x005 with mem word 0x11223344 at word 1 (MEM_LAT=1) -> mem_rden in C2 at mem_address=1, dv in C4, p_rdata=0x33, miss_cnt=1.
REQ-022 Repeat read 0x006 -> no mem_rden, dv in C2, p_rdata=0x22, hit_cnt=1.
REQ-023 Write 0xAB to 0x007 (hit) -> mem_wren in C2, byteen=4'b1000, mem_wdata=0xABABABAB, dv in C3; then read 0x007 -> hit, p_rdata=0xAB.
REQ-024 Read 0x025 (same index 1, different tag) -> miss, refill; then read 0x005 -> miss again (conflict eviction).
REQ-025 flush asserted with p_req in IDLE -> flush only, busy for one cycle; subsequent read 0x005 -> miss.
REQ-026 rst asserted in MEM_WAIT of a miss -> no dv, counters 0, next read of same address -> miss; miss_cnt saturates at 0xFFFF with CNT_W=16.

Source files
------------

// File: rtl/dm_cache_ctrl_if.sv
// Processor- and memory-side signal bundle for the direct-mapped cache controller.
// The cache uses the slave view; a processor/memory model uses the master view.
interface dm_cache_ctrl_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned CNT_W  = 16
);
    logic              p_req;
    logic              p_wren;
    logic [ADDR_W-1:0] p_address;
    logic [7:0]        p_wdata;
    logic [7:0]        p_rdata;
    logic              dv;
    logic              busy;
    logic              flush;
    logic [ADDR_W-3:0] mem_address;
    logic              mem_rden;
    logic              mem_wren;
    logic [3:0]        mem_byteen;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output p_req, p_wren, p_address, p_wdata, flush, mem_rdata,
        input  p_rdata, dv, busy, mem_address, mem_rden, mem_wren, mem_byteen, mem_wdata,
               hit_cnt, miss_cnt
    );

    modport slave (
        input  p_req, p_wren, p_address, p_wdata, flush, mem_rdata,
        output p_rdata, dv, busy, mem_address, mem_rden, mem_wren, mem_byteen, mem_wdata,
               hit_cnt, miss_cnt
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache of one 32-bit word per line,
// with byte-wide processor access, flush and saturating hit/miss counters.
module dm_cache_ctrl #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input logic            clk,
    input logic            rst,
    dm_cache_ctrl_if.slave bus
);
    localparam int unsigned TagW  = ADDR_W - 2 - IDX_W;
    localparam int unsigned Lines = 1 << IDX_W;

    typedef enum logic [2:0] {StIdle, StCompare, StMemRd, StMemWait, StMemWr, StFlush} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [Lines-1:0]  valid_q, valid_d;
    logic [TagW-1:0]   tag_q [Lines];
    logic [TagW-1:0]   tag_d [Lines];
    logic [31:0]       data_q [Lines];
    logic [31:0]       data_d [Lines];
    logic [1:0]        wait_q, wait_d;
    logic              dv_q, dv_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [ADDR_W-3:0] mem_address_q, mem_address_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]  idx;
    logic [TagW-1:0]   tag;
    logic [1:0]        off;
    logic              hit;
    logic [31:0]       word_wr;

    assign idx = addr_q[IDX_W+1:2];
    assign tag = addr_q[ADDR_W-1:IDX_W+2];
    assign off = addr_q[1:0];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        word_wr = data_q[idx];
        word_wr[{off, 3'b000} +: 8] = wdata_q;
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wren_d        = wren_q;
        wdata_d       = wdata_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        data_d        = data_q;
        wait_d        = wait_q;
        dv_d          = 1'b0;
        rdata_d       = rdata_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;

        unique case (state_q)
            StIdle: begin
                // Flush takes priority; a simultaneous request is simply not accepted.
                if (bus.flush) begin
                    state_d = StFlush;
                end else if (bus.p_req) begin
                    addr_d  = bus.p_address;
                    wren_d  = bus.p_wren;
                    wdata_d = bus.p_wdata;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                mem_address_d = addr_q[ADDR_W-1:2];
                mem_wdata_d   = {4{wdata_q}};
                if (hit) begin
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                end
                if (wren_q) begin
                    if (hit) data_d[idx] = word_wr;
                    state_d = StMemWr;
                end else if (hit) begin
                    rdata_d = data_q[idx][{off, 3'b000} +: 8];
                    dv_d    = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StMemRd;
                end
            end
            StMemRd: begin
                wait_d  = 2'(MEM_LAT - 1);
                state_d = StMemWait;
            end
            StMemWait: begin
                if (wait_q == 2'd0) begin
                    valid_d[idx] = 1'b1;
                    tag_d[idx]   = tag;
                    data_d[idx]  = bus.mem_rdata;
                    rdata_d      = bus.mem_rdata[{off, 3'b000} +: 8];
                    dv_d         = 1'b1;
                    state_d      = StIdle;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            StMemWr: begin
                dv_d    = 1'b1;
                state_d = StIdle;
            end
            StFlush: begin
                valid_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wren_q        <= 1'b0;
            wdata_q       <= '0;
            valid_q       <= '0;
            wait_q        <= '0;
            dv_q          <= 1'b0;
            rdata_q       <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wren_q        <= wren_d;
            wdata_q       <= wdata_d;
            valid_q       <= valid_d;
            wait_q        <= wait_d;
            dv_q          <= dv_d;
            rdata_q       <= rdata_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    // Tag and data arrays are qualified by the valid bits, so they are never reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.dv          = dv_q;
    assign bus.p_rdata     = rdata_q;
    assign bus.mem_rden    = (state_q == StMemRd);
    assign bus.mem_wren    = (state_q == StMemWr);
    assign bus.mem_byteen  = (state_q == StMemWr) ? (4'b0001 << off) : 4'b0000;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.hit_cnt     = hit_cnt_q;
    assign bus.miss_cnt    = miss_cnt_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench: a word-granular cache/memory reference model predicts every completion
// and memory access; a negedge monitor pops and compares as the DUT presents them.
module tb_dm_cache_ctrl;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned MEM_LAT = 1;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned S_LAT   = 3;
    localparam int unsigned S_CNT   = 3;
    localparam int          MAXC    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    logic mem_init;
    always #5 clk = ~clk;

    dm_cache_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
    dm_cache_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(S_CNT)) sbus ();

    dm_cache_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dm_cache_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .MEM_LAT(S_LAT), .CNT_W(S_CNT)) u_sat (
        .clk (clk),
        .rst (rst_s),
        .bus (sbus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'h1122_3344 : (i * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    function automatic logic [31:0] spat(input logic [6:0] w);
        return (32'h0101_0101 * {25'd0, w}) ^ 32'hA5C3_0F96;
    endfunction

    // Memory models: data valid exactly MEM_LAT cycles after the read strobe, junk otherwise.
    logic [31:0] mem_arr [128];
    logic [31:0] junk;
    int          rd_cnt = 0;
    logic [6:0]  rd_addr;
    int          rs_cnt = 0;
    logic [6:0]  rs_addr;

    always @(posedge clk) begin
        junk <= $urandom;
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem_arr[i] <= init_word(i);
        end else if (bus.mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_byteen[b]) mem_arr[bus.mem_address][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        if (bus.mem_rden) begin
            rd_cnt  <= MEM_LAT;
            rd_addr <= bus.mem_address;
        end else if (rd_cnt > 0) begin
            rd_cnt <= rd_cnt - 1;
        end
        if (sbus.mem_rden) begin
            rs_cnt  <= S_LAT;
            rs_addr <= sbus.mem_address;
        end else if (rs_cnt > 0) begin
            rs_cnt <= rs_cnt - 1;
        end
    end
    assign bus.mem_rdata  = (rd_cnt == 1) ? mem_arr[rd_addr] : junk;
    assign sbus.mem_rdata = (rs_cnt == 1) ? spat(rs_addr) : junk;

    // Reference model: each line remembers which memory word it holds (-1 = empty).
    logic [31:0] ref_mem [128];
    int          line_word [8];
    int          exp_hit;
    int          exp_miss;
    logic [7:0]  last_rd;

    typedef struct { int due; logic [7:0] rdata; } resp_t;
    typedef struct { int due; bit wr; logic [6:0] addr; logic [3:0] be; logic [31:0] wd; } mop_t;
    resp_t rq [$];
    mop_t  mq [$];
    resp_t mon_r;
    mop_t  mon_m;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) line_word[i] = -1;
        exp_hit  = 0;
        exp_miss = 0;
        last_rd  = 8'h00;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dv) begin
                if (rq.size() == 0) begin
                    note_fail("dv_expected_none");
                end else begin
                    mon_r = rq.pop_front();
                    check("dv_cycle", cyc, mon_r.due);
                    check("p_rdata", bus.p_rdata, mon_r.rdata);
                end
            end
            if (bus.mem_rden || bus.mem_wren) begin
                check("mem_rd_wr_exclusive", {31'd0, bus.mem_rden & bus.mem_wren}, 32'd0);
                if (mq.size() == 0) begin
                    note_fail("mem_access_expected_none");
                end else begin
                    mon_m = mq.pop_front();
                    check("mem_cycle", cyc, mon_m.due);
                    check("mem_wren", {31'd0, bus.mem_wren}, {31'd0, mon_m.wr});
                    check("mem_address", bus.mem_address, mon_m.addr);
                    if (mon_m.wr) begin
                        check("mem_byteen", bus.mem_byteen, mon_m.be);
                        check("mem_wdata", bus.mem_wdata, mon_m.wd);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (bus.busy !== 1'b0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (bus.busy !== 1'b0) note_fail("idle_timeout");
    endtask

    task automatic drain();
        int g = 0;
        while ((rq.size() != 0 || mq.size() != 0) && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (rq.size() != 0 || mq.size() != 0) note_fail("drain_timeout");
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input bit wr, input logic [8:0] a, input logic [7:0] wd);
        logic [6:0]  w;
        logic [31:0] word;
        logic [7:0]  b;
        int ix, off, acc;
        bit h;
        mop_t  m;
        resp_t r;
        wait_idle();
        bus.p_req     = 1'b1;
        bus.p_wren    = wr;
        bus.p_address = a;
        bus.p_wdata   = wd;
        acc = cyc;
        w   = a[8:2];
        ix  = int'(a[4:2]);
        off = int'(a[1:0]);
        h   = (line_word[ix] == int'(w));
        if (h) exp_hit = (exp_hit == MAXC) ? MAXC : exp_hit + 1;
        else   exp_miss = (exp_miss == MAXC) ? MAXC : exp_miss + 1;
        word = ref_mem[w];
        b    = word[off*8 +: 8];
        if (wr) begin
            m.due = acc + 2; m.wr = 1'b1; m.addr = w; m.be = 4'b0001 << off; m.wd = {4{wd}};
            mq.push_back(m);
            ref_mem[w][off*8 +: 8] = wd;
            r.due = acc + 3; r.rdata = last_rd;
            rq.push_back(r);
        end else begin
            if (!h) begin
                m.due = acc + 2; m.wr = 1'b0; m.addr = w; m.be = 4'b0000; m.wd = '0;
                mq.push_back(m);
                line_word[ix] = int'(w);
            end
            last_rd = b;
            r.due   = h ? acc + 2 : acc + 3 + int'(MEM_LAT);
            r.rdata = b;
            rq.push_back(r);
        end
        @(negedge clk);
        bus.p_req = 1'b0;
    endtask

    task automatic do_flush(input bit with_req);
        wait_idle();
        bus.flush     = 1'b1;
        bus.p_req     = with_req;
        bus.p_wren    = 1'b0;
        bus.p_address = 9'h005;
        @(negedge clk);
        check("flush_busy", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b0;
        bus.p_req = 1'b0;
        for (int i = 0; i < 8; i++) line_word[i] = -1;
        @(negedge clk);
        check("flush_one_cycle", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_reset_state();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_dv", {31'd0, bus.dv}, 32'd0);
        check("rst_mem_rden", {31'd0, bus.mem_rden}, 32'd0);
        check("rst_mem_wren", {31'd0, bus.mem_wren}, 32'd0);
        check("rst_mem_byteen", bus.mem_byteen, 32'd0);
        check("rst_mem_address", bus.mem_address, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_p_rdata", bus.p_rdata, 32'd0);
        check("rst_hit_cnt", bus.hit_cnt, 32'd0);
        check("rst_miss_cnt", bus.miss_cnt, 32'd0);
    endtask

    task automatic s_read(input logic [8:0] a, input bit h);
        int acc, g;
        logic [31:0] w;
        logic [7:0]  b;
        g = 0;
        while (sbus.busy !== 1'b0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        sbus.p_req     = 1'b1;
        sbus.p_address = a;
        acc = cyc;
        @(negedge clk);
        sbus.p_req = 1'b0;
        g = 0;
        while (sbus.dv !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (sbus.dv !== 1'b1) begin
            note_fail("sat_dv_timeout");
        end else begin
            check("sat_dv_cycle", cyc, h ? acc + 2 : acc + 3 + int'(S_LAT));
            w = spat(a[8:2]);
            b = w[8*a[1:0] +: 8];
            check("sat_p_rdata", sbus.p_rdata, b);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rst_s = 1'b1; mem_init = 1'b1;
        bus.p_req = 1'b0; bus.p_wren = 1'b0; bus.p_address = '0; bus.p_wdata = '0; bus.flush = 1'b0;
        sbus.p_req = 1'b0; sbus.p_wren = 1'b0; sbus.p_address = '0; sbus.p_wdata = '0;
        sbus.flush = 1'b0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        model_reset();
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        check_reset_state();
        rst = 1'b0;

        // Directed: first miss, hit, write hit, read-after-write, conflict eviction.
        issue(1'b0, 9'h005, 8'h00);
        issue(1'b0, 9'h006, 8'h00);
        issue(1'b1, 9'h007, 8'hAB);
        issue(1'b0, 9'h007, 8'h00);
        issue(1'b0, 9'h025, 8'h00);
        issue(1'b0, 9'h005, 8'h00);
        issue(1'b1, 9'h0C9, 8'h5E);
        issue(1'b0, 9'h0C9, 8'h00);
        drain();
        check("dir_hit_cnt", bus.hit_cnt, exp_hit);
        check("dir_miss_cnt", bus.miss_cnt, exp_miss);

        do_flush(1'b1);
        issue(1'b0, 9'h005, 8'h00);
        drain();
        check("flush_miss_cnt", bus.miss_cnt, exp_miss);

        // Random traffic over few tags so hits, misses and evictions all occur.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_flush(1'($urandom_range(0, 1)));
            end else begin
                issue(($urandom_range(0, 2) == 0),
                      {5'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), 2'($urandom)},
                      8'($urandom));
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();
        check("rand_hit_cnt", bus.hit_cnt, exp_hit);
        check("rand_miss_cnt", bus.miss_cnt, exp_miss);

        // Reset while a miss sits in the memory wait.
        do_flush(1'b0);
        issue(1'b0, 9'h041, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        rq.delete();
        mq.delete();
        model_reset();
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue(1'b0, 9'h041, 8'h00);
        drain();
        check("post_rst_miss_cnt", bus.miss_cnt, exp_miss);
        check("post_rst_hit_cnt", bus.hit_cnt, exp_hit);

        // Saturation and longer latency on the narrow-counter instance.
        rst_s = 1'b0;
        for (int k = 0; k < 10; k++) s_read((k % 2 == 0) ? 9'h005 : 9'h025, 1'b0);
        check("sat_miss_cnt", sbus.miss_cnt, 32'd7);
        check("sat_hit_cnt0", sbus.hit_cnt, 32'd0);
        s_read(9'h026, 1'b1);
        check("sat_hit_cnt1", sbus.hit_cnt, 32'd1);
        check("sat_miss_hold", sbus.miss_cnt, 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
